regfile: RTL and testbench

- 32-entry x 32-bit integer register file for the RV32I pipelined core, used in the decode stage.
- Two asynchronous (combinational) read ports (A1/RD1, A2/RD2) and one synchronous write port (A3/WD3/write_en) written from writeback.
- Register x0 is hardwired to zero.
- Synchronous clear of all registers on reset.

---
 rtl/regfile.sv | 57 +++++
 tb/tb_regfile.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// 32 x XLEN integer register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero, synchronous active-low clear of all entries.
module regfile #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter bit WR_BYPASS = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_en,
    input  logic [$clog2(NREGS)-1:0] A1,
    input  logic [$clog2(NREGS)-1:0] A2,
    input  logic [$clog2(NREGS)-1:0] A3,
    input  logic [XLEN-1:0]          WD3,
    output logic [XLEN-1:0]          RD1,
    output logic [XLEN-1:0]          RD2
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_active;

    assign wr_active = reset && write_en && (A3 != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[A3] <= WD3;
        end
    end

    // x0 is forced to zero on the read side so it never depends on storage contents
    always_comb begin
        RD1 = regs[A1];
        if (WR_BYPASS && wr_active && (A1 == A3)) begin
            RD1 = WD3;
        end
        if (A1 == AW'(0)) begin
            RD1 = '0;
        end
    end

    always_comb begin
        RD2 = regs[A2];
        if (WR_BYPASS && wr_active && (A2 == A3)) begin
            RD2 = WD3;
        end
        if (A2 == AW'(0)) begin
            RD2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: scenario tasks push expected read results to a
// scoreboard queue, then drain it by driving read addresses and comparing outputs.
module tb_regfile;

    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam bit WR_BYPASS = 1'b0;

    logic            clk;
    logic            reset;
    logic            write_en;
    logic [4:0]      A1, A2, A3;
    logic [XLEN-1:0] WD3;
    logic [XLEN-1:0] RD1, RD2;

    typedef struct {
        logic [4:0]      a1;
        logic [4:0]      a2;
        logic [XLEN-1:0] e1;
        logic [XLEN-1:0] e2;
        string           name;
    } exp_t;

    exp_t            sb[$];
    logic [XLEN-1:0] model [NREGS];
    int              errors = 0;
    int              checks = 0;

    regfile #(.XLEN(XLEN), .NREGS(NREGS), .WR_BYPASS(WR_BYPASS)) dut (
        .clk(clk), .reset(reset), .write_en(write_en),
        .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
        .RD1(RD1), .RD2(RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus: one write over one rising edge, mirrored into the bench model
    task automatic wr(input logic [4:0] addr, input logic [XLEN-1:0] data);
        write_en = 1'b1;
        A3       = addr;
        WD3      = data;
        @(posedge clk);
        #1;
        write_en = 1'b0;
        if (reset && addr != 5'd0) model[addr] = data;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    task automatic test_reset();
        exp_t e;
        pulse_reset();
        sb.push_back('{5'd5, 5'd31, 32'd0, 32'd0, "reset_5_31"});
        sb.push_back('{5'd17, 5'd1, 32'd0, 32'd0, "reset_17_1"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            A1 = e.a1; A2 = e.a2; #1;
            checks++;
            if (RD1 !== e.e1) begin errors++; $display("FAIL %s RD1 got=%0d exp=%0d", e.name, RD1, e.e1); end
            checks++;
            if (RD2 !== e.e2) begin errors++; $display("FAIL %s RD2 got=%0d exp=%0d", e.name, RD2, e.e2); end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        wr(5'd1, 32'd42);
        sb.push_back('{5'd1, 5'd0, 32'd42, 32'd0, "write_x1"});
        sb.push_back('{5'd0, 5'd1, 32'd0, 32'd42, "write_x1_port2"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            A1 = e.a1; A2 = e.a2; #1;
            checks++;
            if (RD1 !== e.e1) begin errors++; $display("FAIL %s RD1 got=%0d exp=%0d", e.name, RD1, e.e1); end
            checks++;
            if (RD2 !== e.e2) begin errors++; $display("FAIL %s RD2 got=%0d exp=%0d", e.name, RD2, e.e2); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        write_en = 1'b1; A3 = 5'd2; WD3 = 32'd100;
        @(posedge clk); #1;
        A3 = 5'd3; WD3 = 32'd200;
        @(posedge clk); #1;
        write_en = 1'b0;
        model[2] = 32'd100; model[3] = 32'd200;
        sb.push_back('{5'd2, 5'd3, 32'd100, 32'd200, "b2b_2_3"});
        sb.push_back('{5'd1, 5'd2, 32'd42, 32'd100, "b2b_1_2"});
        sb.push_back('{5'd3, 5'd3, 32'd200, 32'd200, "same_addr_both"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            A1 = e.a1; A2 = e.a2; #1;
            checks++;
            if (RD1 !== e.e1) begin errors++; $display("FAIL %s RD1 got=%0d exp=%0d", e.name, RD1, e.e1); end
            checks++;
            if (RD2 !== e.e2) begin errors++; $display("FAIL %s RD2 got=%0d exp=%0d", e.name, RD2, e.e2); end
        end
    endtask

    task automatic test_x0();
        exp_t e;
        wr(5'd0, 32'd999);
        sb.push_back('{5'd0, 5'd0, 32'd0, 32'd0, "x0_after_write"});
        sb.push_back('{5'd0, 5'd1, 32'd0, 32'd42, "x0_neighbour"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            A1 = e.a1; A2 = e.a2; #1;
            checks++;
            if (RD1 !== e.e1) begin errors++; $display("FAIL %s RD1 got=%0d exp=%0d", e.name, RD1, e.e1); end
            checks++;
            if (RD2 !== e.e2) begin errors++; $display("FAIL %s RD2 got=%0d exp=%0d", e.name, RD2, e.e2); end
        end
        // x0 while a same-cycle write targets x0
        write_en = 1'b1; A3 = 5'd0; WD3 = 32'hdead_beef; A1 = 5'd0; A2 = 5'd0; #1;
        checks++;
        if (RD1 !== 32'd0) begin errors++; $display("FAIL x0_samecycle RD1 got=%0d exp=0", RD1); end
        write_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        reset = 1'b0;
        write_en = 1'b1; A3 = 5'd4; WD3 = 32'd7;
        A1 = 5'd1; #1;
        checks++;
        if (RD1 !== 32'd42) begin errors++; $display("FAIL reset_not_async RD1 got=%0d exp=42", RD1); end
        @(posedge clk); #1;
        write_en = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        sb.push_back('{5'd1, 5'd2, 32'd0, 32'd0, "midreset_1_2"});
        sb.push_back('{5'd4, 5'd3, 32'd0, 32'd0, "midreset_x4_priority"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            A1 = e.a1; A2 = e.a2; #1;
            checks++;
            if (RD1 !== e.e1) begin errors++; $display("FAIL %s RD1 got=%0d exp=%0d", e.name, RD1, e.e1); end
            checks++;
            if (RD2 !== e.e2) begin errors++; $display("FAIL %s RD2 got=%0d exp=%0d", e.name, RD2, e.e2); end
        end
    endtask

    task automatic test_write_disable();
        exp_t e;
        write_en = 1'b0; A3 = 5'd5; WD3 = 32'd55;
        @(posedge clk); #1;
        sb.push_back('{5'd5, 5'd0, 32'd0, 32'd0, "no_write_x5"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            A1 = e.a1; A2 = e.a2; #1;
            checks++;
            if (RD1 !== e.e1) begin errors++; $display("FAIL %s RD1 got=%0d exp=%0d", e.name, RD1, e.e1); end
            checks++;
            if (RD2 !== e.e2) begin errors++; $display("FAIL %s RD2 got=%0d exp=%0d", e.name, RD2, e.e2); end
        end
    endtask

    task automatic test_same_cycle();
        exp_t e;
        write_en = 1'b1; A3 = 5'd6; WD3 = 32'd9;
        sb.push_back('{5'd6, 5'd6, (WR_BYPASS ? 32'd9 : 32'd0), (WR_BYPASS ? 32'd9 : 32'd0), "samecycle_before"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            A1 = e.a1; A2 = e.a2; #1;
            checks++;
            if (RD1 !== e.e1) begin errors++; $display("FAIL %s RD1 got=%0d exp=%0d", e.name, RD1, e.e1); end
            checks++;
            if (RD2 !== e.e2) begin errors++; $display("FAIL %s RD2 got=%0d exp=%0d", e.name, RD2, e.e2); end
        end
        @(posedge clk); #1;
        write_en = 1'b0;
        model[6] = 32'd9;
        sb.push_back('{5'd6, 5'd0, 32'd9, 32'd0, "samecycle_after"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            A1 = e.a1; A2 = e.a2; #1;
            checks++;
            if (RD1 !== e.e1) begin errors++; $display("FAIL %s RD1 got=%0d exp=%0d", e.name, RD1, e.e1); end
            checks++;
            if (RD2 !== e.e2) begin errors++; $display("FAIL %s RD2 got=%0d exp=%0d", e.name, RD2, e.e2); end
        end
    endtask

    task automatic test_random();
        exp_t        e;
        logic [4:0]  a, r1, r2;
        logic [31:0] d;
        for (int n = 0; n < 40; n++) begin
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            wr(a, d);
            r1 = 5'($urandom_range(0, 31));
            r2 = 5'($urandom_range(0, 31));
            sb.push_back('{a, r1, model[a], model[r1], "random_wr"});
            sb.push_back('{r2, a, model[r2], model[a], "random_rd"});
            while (sb.size() > 0) begin
                e = sb.pop_front();
                A1 = e.a1; A2 = e.a2; #1;
                checks++;
                if (RD1 !== e.e1) begin errors++; $display("FAIL %s A1=%0d RD1 got=%0h exp=%0h", e.name, e.a1, RD1, e.e1); end
                checks++;
                if (RD2 !== e.e2) begin errors++; $display("FAIL %s A2=%0d RD2 got=%0h exp=%0h", e.name, e.a2, RD2, e.e2); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; write_en = 1'b0;
        A1 = '0; A2 = '0; A3 = '0; WD3 = '0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_x0();
        test_reset_mid();
        test_write_disable();
        test_same_cycle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
